scan_ctrl: RTL and testbench

- Sequencer that drives the 8-bit scan chain register's control pins (scan_en, scan_in, shift, enable) and reads back through its scan_out.
- Accepts a command over valid/ready: pattern to load, number of functional shift cycles, shift direction.
- Serially loads the pattern, runs the chain in functional mode for N cycles, serially unloads the result, and returns it over valid/ready.
- Sits directly upstream of the chain (drives it) and downstream of the test/config master.

---
 rtl/scan_pkg.sv | 31 +++
 rtl/scan_ctrl_if.sv | 41 ++++
 rtl/scan_ctrl_shifter.sv | 98 +++++++++
 rtl/scan_ctrl.sv | 138 +++++++++++++
 tb/tb_scan_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain sequencer.
// Optional feature macro used across this slice: SCAN_CTRL_PARITY_EN.
package scan_pkg;

    // Sequencer phases: accept a command, shift the pattern in, clock the
    // chain functionally, shift the result out, hand the result back.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        UNLOAD = 3'd3,
        RESP   = 3'd4
    } scan_ctrl_state_t;

    // Default geometry of the attached chain and of the run-count field.
    localparam int SCAN_CHAIN_LEN = 8;
    localparam int SCAN_RUN_W     = 8;

    // Width of a counter that must hold the values 0..chain_len.
    function automatic int scan_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Bit counter width for the default chain.
    localparam int SCAN_BIT_CNT_W = $clog2(SCAN_CHAIN_LEN + 1);

    // Functional shift direction as presented on the chain's shift pin.
    localparam logic DIR_LEFT  = 1'b1;  // left, zero fill
    localparam logic DIR_RIGHT = 1'b0;  // right, one fill

endpackage : scan_pkg

// File: rtl/scan_ctrl_if.sv
// Command/response bus between the test/config master and scan_ctrl.
// With SCAN_CTRL_PARITY_EN defined the response also carries rsp_parity.
interface scan_ctrl_if #(
    parameter int CHAIN_LEN = scan_pkg::SCAN_CHAIN_LEN,
    parameter int RUN_W     = scan_pkg::SCAN_RUN_W
);

    // Command channel: pattern, functional cycle count, run direction.
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CHAIN_LEN-1:0] cmd_data;
    logic [RUN_W-1:0]     cmd_run;
    logic                 cmd_dir;

    // Response channel: chain contents after the run.
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
`ifdef SCAN_CTRL_PARITY_EN
    logic                 rsp_parity;
`endif

    // The test/config master issues commands and consumes responses.
    modport master (
        output cmd_valid, cmd_data, cmd_run, cmd_dir, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
`ifdef SCAN_CTRL_PARITY_EN
        , input rsp_parity
`endif
    );

    // The sequencer accepts commands and produces responses.
    modport slave (
        input  cmd_valid, cmd_data, cmd_run, cmd_dir, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
`ifdef SCAN_CTRL_PARITY_EN
        , output rsp_parity
`endif
    );

endinterface : scan_ctrl_if

// File: rtl/scan_ctrl_shifter.sv
// Serial datapath of the sequencer: a parallel-load/serial-out register that
// feeds the chain's scan_in, a serial-in/parallel-out register that collects
// the chain's scan_out, and the shared bit counter that sizes both phases.
// With SCAN_CTRL_PARITY_EN defined a running parity of the captured bits is kept.
module scan_ctrl_shifter
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,       // parallel load of a new pattern
    input  logic                 shift_out_i,  // one serial bit towards the chain
    input  logic                 capture_i,    // one serial bit from the chain
    input  logic [CHAIN_LEN-1:0] pdata_i,
    input  logic                 sin_i,
    output logic                 sout_o,
    output logic [CHAIN_LEN-1:0] cap_data_o,
    output logic                 last_o        // final bit of a LOAD/UNLOAD phase
`ifdef SCAN_CTRL_PARITY_EN
    ,
    output logic                 parity_o
`endif
);

    localparam int CNT_W = scan_cnt_w(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] ld_q, ld_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign last_o     = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign sout_o     = ld_q[CHAIN_LEN-1];
    assign cap_data_o = cap_q;

    // Next-state of the load shifter, capture shifter and bit counter.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ld_d  = ld_q;
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ld_d = pdata_i;
        end else if (shift_out_i) begin
            ld_d = {ld_q[CHAIN_LEN-2:0], 1'b0};
        end
        if (capture_i) begin
            cap_d = {cap_q[CHAIN_LEN-2:0], sin_i};
        end
        if (shift_out_i || capture_i) begin
            // Each phase is exactly CHAIN_LEN bits, so wrapping on the last
            // bit leaves the counter at 0 for the next phase.
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers, cleared by the shared chain reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values of its inputs.
        if (!reset) begin
            ld_q  <= '0;
            cap_q <= '0;
            cnt_q <= '0;
        end else begin
            ld_q  <= ld_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SCAN_CTRL_PARITY_EN
    logic par_q, par_d;

    assign parity_o = par_q;

    // Running parity: cleared with each new command, toggled by captured ones.
    always_comb begin
        par_d = par_q;
        if (load_i) begin
            par_d = 1'b0;
        end else if (capture_i) begin
            par_d = par_q ^ sin_i;
        end
    end

    // Parity register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule : scan_ctrl_shifter

// File: rtl/scan_ctrl.sv
// Scan chain sequencer: takes a command (pattern, run count, direction),
// serially loads the chain, clocks it functionally, unloads it and returns
// the result. All chain controls are Moore outputs of the current phase.
// Optional feature macro: SCAN_CTRL_PARITY_EN (adds rsp_parity on the bus).
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
    parameter int RUN_W     = SCAN_RUN_W
) (
    input  logic       clk,
    input  logic       reset,
    scan_ctrl_if.slave bus,
    output logic       scan_en,
    output logic       scan_in,
    output logic       enable,
    output logic       shift,
    input  logic       scan_out
);

    scan_ctrl_state_t state_q, state_d;

    logic [RUN_W-1:0]     run_q, run_d;
    logic                 dir_q, dir_d;
    logic                 cmd_ready_q;
    logic                 cmd_fire;
    logic                 rsp_valid;
    logic                 sout;
    logic                 last_bit;
    logic [CHAIN_LEN-1:0] cap_data;

    // Commands are only taken in IDLE; cmd_* is ignored everywhere else.
    assign cmd_fire      = bus.cmd_valid && cmd_ready_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = cap_data;

    scan_ctrl_shifter #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (cmd_fire),
        .shift_out_i (state_q == LOAD),
        .capture_i   (state_q == UNLOAD),
        .pdata_i     (bus.cmd_data),
        .sin_i       (scan_out),
        .sout_o      (sout),
        .cap_data_o  (cap_data),
        .last_o      (last_bit)
`ifdef SCAN_CTRL_PARITY_EN
        ,
        .parity_o    (bus.rsp_parity)
`endif
    );

    // State register plus command fields latched at the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= '0;
            dir_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            dir_q       <= dir_d;
            // Ready is held low during reset and follows IDLE afterwards, so
            // it reasserts the cycle after a response handshake.
            cmd_ready_q <= (state_d == IDLE);
        end
    end

    // Phase sequencing and run counter update.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    run_d   = bus.cmd_run;
                    dir_d   = bus.cmd_dir;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (last_bit) begin
                    state_d = (run_q != '0) ? RUN : UNLOAD;
                end
            end
            RUN: begin
                run_d = run_q - RUN_W'(1);
                if (run_q == RUN_W'(1)) begin
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (last_bit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: chain controls and response valid from the current phase.
    always_comb begin
        scan_en   = 1'b0;
        scan_in   = 1'b0;
        enable    = 1'b0;
        shift     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            LOAD: begin
                scan_en = 1'b1;
                scan_in = sout;
            end
            RUN: begin
                enable = 1'b1;
                shift  = (dir_q == DIR_LEFT) ? DIR_LEFT : DIR_RIGHT;
            end
            UNLOAD: begin
                scan_en = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : scan_ctrl

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl driving a behavioural 8-bit scan chain register.
// Define SCAN_CTRL_PARITY_EN to also check rsp_parity.
module tb_scan_ctrl;
    import scan_pkg::*;

    localparam int L  = 8;
    localparam int RW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic scan_en, scan_in, enable, shift, scan_out;
    logic [L-1:0] chain;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_ctrl_if #(.CHAIN_LEN(L), .RUN_W(RW)) bus ();

    scan_ctrl #(.CHAIN_LEN(L), .RUN_W(RW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .enable   (enable),
        .shift    (shift),
        .scan_out (scan_out)
    );

    // The attached chain: serial shift in scan mode, functional shift otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else if (scan_en) begin
            chain <= {chain[L-2:0], scan_in};
        end else if (enable) begin
            if (shift == DIR_LEFT) chain <= {chain[L-2:0], 1'b0};
            else                   chain <= {1'b1, chain[L-1:1]};
        end
    end
    assign scan_out = chain[L-1];

    // Expected chain contents after 'run' functional shifts of pattern d.
    function automatic logic [7:0] model(input logic [7:0] d, input int run, input logic dir);
        logic [7:0] r;
        logic [7:0] keep;
        if (run >= L) return dir ? 8'h00 : 8'hFF;
        if (dir) begin
            r = d << run;
        end else begin
            keep = 8'hFF >> run;
            r = (d >> run) | ~keep;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command: handshake, latency/enable/data checks, optional
    // backpressure with a competing command held on the bus, rsp handshake.
    task automatic run_cmd(input logic [7:0] d, input int run, input logic dir,
                           input int hold, input logic press, input string tag);
        int lat;
        int en_cnt;
        int waitc;
        logic [7:0] exp;
        logic [7:0] held;
        exp = model(d, run, dir);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_run   = RW'(run);
        bus.cmd_dir   = dir;
        waitc = 0;
        while (!bus.cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " cmd_ready"}, bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        bus.cmd_run   = RW'($urandom);
        bus.cmd_dir   = 1'($urandom);
        lat    = 0;
        en_cnt = 0;
        while (!bus.rsp_valid && lat < 600) begin
            if (enable) en_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 2 * L + run);
        check({tag, " enable_cycles"}, en_cnt, run);
        check({tag, " rsp_data"}, bus.rsp_data, exp);
`ifdef SCAN_CTRL_PARITY_EN
        check({tag, " rsp_parity"}, bus.rsp_parity, ^exp);
`endif
        held = bus.rsp_data;
        if (press) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = 8'h5A;
            bus.cmd_run   = '0;
            bus.cmd_dir   = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold rsp_valid"}, bus.rsp_valid, 1);
            check({tag, " hold rsp_data"}, bus.rsp_data, held);
            check({tag, " hold cmd_ready"}, bus.cmd_ready, 0);
            check({tag, " hold controls"}, {scan_en, scan_in, enable, shift}, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
        check({tag, " cmd_ready back"}, bus.cmd_ready, 1);
    endtask

    initial begin
        logic [7:0] d;
        int         run;
        logic       dir;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_run   = '0;
        bus.cmd_dir   = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state, including ready held low while reset is asserted.
        #2 reset = 1'b0;
        #1;
        check("reset outputs", {scan_en, scan_in, enable, shift, bus.rsp_valid, bus.cmd_ready}, 0);
        check("reset rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready after reset", bus.cmd_ready, 1);

        // Directed cases.
        run_cmd(8'hA5, 0, DIR_LEFT,  0, 1'b0, "pass");
        run_cmd(8'hA5, 3, DIR_LEFT,  0, 1'b0, "left");
        run_cmd(8'hA5, 3, DIR_RIGHT, 0, 1'b0, "right");
        run_cmd(8'hC3, 2, DIR_LEFT,  5, 1'b1, "backpressure");
        run_cmd(8'h5A, 0, DIR_RIGHT, 0, 1'b0, "after_bp");

        // Reset during the 4th LOAD cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hFF;
        bus.cmd_run   = RW'(5);
        bus.cmd_dir   = DIR_LEFT;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midload scan_en", scan_en, 1);
        reset = 1'b0;
        #1;
        check("midload reset outputs", {scan_en, scan_in, enable, shift, bus.rsp_valid, bus.cmd_ready}, 0);
        check("midload reset rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midload ready", bus.cmd_ready, 1);
        run_cmd(8'h3C, 0, DIR_LEFT, 0, 1'b0, "post_reset");

        // Boundary run counts, then randomized commands.
        run_cmd(8'h81, 1, DIR_RIGHT, 1, 1'b0, "run1");
        run_cmd(8'($urandom), 255, 1'($urandom), 0, 1'b0, "run_max");
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            run = $urandom_range(0, 12);
            dir = 1'($urandom_range(0, 1));
            run_cmd(d, run, dir, $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scan_ctrl
